// File: rtl/hps_gp_responder.sv
// -----------------------------------------------------------------------------
// hps_gp_responder
//
// Fabric-side responder for the HPS general-purpose register mailbox. The HPS
// posts an 8-bit read or write request on its GP output word and flips a
// toggle bit. This block synchronises the word, performs exactly one access
// on the CPC peripheral bus, and reports completion on the GP input word by
// echoing the toggle.
//
// Ports:
//   clk        in   fabric clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   gp_out     in   [31] req toggle, [30] write flag, [29:24] reserved,
//                   [23:8] address, [7:0] write data (async to clk)
//   gp_in      out  [31] ack toggle, [30] error, [29:16] zero,
//                   [15:8] completed-transaction count, [7:0] result byte
//   bus_addr   out  access address (ADDR_W bits)
//   bus_wdata  out  write data
//   bus_rd     out  read strobe, held until bus_ready
//   bus_wr     out  write strobe, held until bus_ready
//   bus_rdata  in   read data, valid when bus_ready=1
//   bus_ready  in   completes the access while a strobe is high
//
// Build option:
//   GP_RESP_TIMEOUT_EN  when defined, an access that sees no bus_ready for
//                       TIMEOUT_CYCLES cycles is aborted with error=1 and
//                       result 0xFF. When undefined, ACCESS waits forever
//                       and gp_in[30] is constant 0.
// -----------------------------------------------------------------------------
module hps_gp_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       gp_out,
  output logic [31:0]       gp_in,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  output logic              bus_rd,
  output logic              bus_wr,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ready
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCESS,
    ST_RESPOND
  } state_e;

`ifdef GP_RESP_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // ---------------------------------------------------------------------------
  // Synchroniser: the whole word goes through the same number of stages. Bits
  // may still arrive on different cycles, which the SETTLE state absorbs.
  // ---------------------------------------------------------------------------
  logic [31:0] sync_word;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [31:0] stage_q;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            stage_q <= '0;
          end else begin
            stage_q <= gp_out;
          end
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            stage_q <= '0;
          end else begin
            stage_q <= g_sync[gi-1].stage_q;
          end
        end
      end
    end
  endgenerate

  assign sync_word = g_sync[SYNC_STAGES-1].stage_q;

  // Reserved request bits (and address bits above ADDR_W) carry no meaning.
  logic unused_sync_bits;
  assign unused_sync_bits = ^sync_word[29:8];

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e            state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [7:0]        wdata_q,     wdata_d;
  logic              wr_flag_q,   wr_flag_d;
  logic              tog_q,       tog_d;       // toggle of the request in flight
  logic              last_tog_q,  last_tog_d;  // toggle of the last served request
  logic              rd_stb_q,    rd_stb_d;
  logic              wr_stb_q,    wr_stb_d;
  logic [7:0]        result_q,    result_d;
  logic              ack_q,       ack_d;
  logic [7:0]        count_q,     count_d;
  logic [7:0]        resp_data_q, resp_data_d;
`ifdef GP_RESP_TIMEOUT_EN
  logic              err_q,       err_d;
  logic              resp_err_q,  resp_err_d;
  logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_flag_d   = wr_flag_q;
    tog_d       = tog_q;
    last_tog_d  = last_tog_q;
    rd_stb_d    = rd_stb_q;
    wr_stb_d    = wr_stb_q;
    result_d    = result_q;
    ack_d       = ack_q;
    count_d     = count_q;
    resp_data_d = resp_data_q;
`ifdef GP_RESP_TIMEOUT_EN
    err_d       = err_q;
    resp_err_d  = resp_err_q;
    to_cnt_d    = to_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Only a change of toggle is a new request; toggle changes arriving
        // while busy are simply picked up here once we are back.
        if (sync_word[31] != last_tog_q) begin
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        // One extra cycle after the toggle is seen so that every other bit of
        // the word has also crossed the synchroniser before it is latched.
        addr_d    = sync_word[8 +: ADDR_W];
        wdata_d   = sync_word[7:0];
        wr_flag_d = sync_word[30];
        tog_d     = sync_word[31];
        rd_stb_d  = !sync_word[30];
        wr_stb_d  = sync_word[30];
`ifdef GP_RESP_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (bus_ready) begin
          result_d = wr_flag_q ? wdata_q : bus_rdata;
          rd_stb_d = 1'b0;
          wr_stb_d = 1'b0;
`ifdef GP_RESP_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = ST_RESPOND;
        end
`ifdef GP_RESP_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          result_d = 8'hFF;
          rd_stb_d = 1'b0;
          wr_stb_d = 1'b0;
          err_d    = 1'b1;
          state_d  = ST_RESPOND;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end

      ST_RESPOND: begin
        resp_data_d = result_q;
        ack_d       = tog_q;
        count_d     = count_q + 8'd1;  // wraps naturally, counts errors too
        last_tog_d  = tog_q;
`ifdef GP_RESP_TIMEOUT_EN
        resp_err_d  = err_q;
`endif
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. Strobes are flops so the asynchronous reset drops them at once.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_flag_q   <= 1'b0;
      tog_q       <= 1'b0;
      last_tog_q  <= 1'b0;
      rd_stb_q    <= 1'b0;
      wr_stb_q    <= 1'b0;
      result_q    <= '0;
      ack_q       <= 1'b0;
      count_q     <= '0;
      resp_data_q <= '0;
`ifdef GP_RESP_TIMEOUT_EN
      err_q       <= 1'b0;
      resp_err_q  <= 1'b0;
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_flag_q   <= wr_flag_d;
      tog_q       <= tog_d;
      last_tog_q  <= last_tog_d;
      rd_stb_q    <= rd_stb_d;
      wr_stb_q    <= wr_stb_d;
      result_q    <= result_d;
      ack_q       <= ack_d;
      count_q     <= count_d;
      resp_data_q <= resp_data_d;
`ifdef GP_RESP_TIMEOUT_EN
      err_q       <= err_d;
      resp_err_q  <= resp_err_d;
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_rd    = rd_stb_q;
  assign bus_wr    = wr_stb_q;

`ifdef GP_RESP_TIMEOUT_EN
  assign gp_in = {ack_q, resp_err_q, 14'd0, count_q, resp_data_q};
`else
  assign gp_in = {ack_q, 1'b0, 14'd0, count_q, resp_data_q};
`endif

endmodule

// File: tb/tb_hps_gp_responder.sv
// -----------------------------------------------------------------------------
// tb_hps_gp_responder
//
// Self-checking bench for hps_gp_responder: directed test-plan sequences, a
// table of request vectors with expected response words, randomized requests
// checked against a transaction-level model (count mod 256, toggle echo,
// result byte), and a mid-access asynchronous reset.
// -----------------------------------------------------------------------------
module tb_hps_gp_responder;

  localparam int SYNC = 2;
  localparam int TO   = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] gp_out;
  logic [31:0] gp_in;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_rdata;
  logic        bus_ready;

  always #5 clk = ~clk;

  hps_gp_responder #(
    .SYNC_STAGES   (SYNC),
    .ADDR_W        (16),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .gp_out   (gp_out),
    .gp_in    (gp_in),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rd   (bus_rd),
    .bus_wr   (bus_wr),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready)
  );

  int          n_checks;
  int          n_fail;
  int          stb_total;
  int          both_hi;
  int          model_cnt;
  logic [31:0] last_exp;

  // Background strobe monitor.
  always @(negedge clk) begin
    if (bus_rd || bus_wr) stb_total++;
    if (bus_rd && bus_wr) both_hi++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_req(input logic tog, input logic wr, input logic [5:0] rsvd,
                                         input logic [15:0] addr, input logic [7:0] wd);
    return {tog, wr, rsvd, addr, wd};
  endfunction

  // Waits for the strobe after a request was posted (or reset released),
  // drives bus_ready after `delay` strobe cycles, and checks the bus access and
  // the response word. exp_stb is the number of cycles the strobe must be high.
  task automatic observe(input string name, input logic [31:0] req, input logic [7:0] rdata,
                         input int delay, input int exp_stb, input logic [31:0] exp_word);
    int   lat;
    int   stb;
    logic wr;
    wr  = req[30];
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!(bus_rd || bus_wr) && lat < 20);
    chk({name, " latency"}, 32'(lat), 32'(SYNC + 2));
    if (!(bus_rd || bus_wr)) return;

    stb = 0;
    while ((bus_rd || bus_wr) && stb < exp_stb + 50) begin
      stb++;
      chk({name, " strobe"}, 32'({bus_wr, bus_rd}), wr ? 32'd2 : 32'd1);
      chk({name, " addr"}, 32'(bus_addr), 32'(req[23:8]));
      chk({name, " wdata"}, 32'(bus_wdata), 32'(req[7:0]));
      bus_rdata = rdata;
      bus_ready = (stb > delay);
      @(posedge clk);
      @(negedge clk);
    end
    bus_ready = 1'b0;
    chk({name, " strobe_cycles"}, 32'(stb), 32'(exp_stb));
    chk({name, " gp_in_before"}, gp_in, last_exp);
    @(posedge clk);
    @(negedge clk);
    chk({name, " gp_in"}, gp_in, exp_word);
    last_exp = exp_word;
    $display("txn %s: req=0x%08h gp_in=0x%08h strobe_cycles=%0d", name, req, gp_in, stb);
  endtask

  task automatic run(input string name, input logic [31:0] req, input logic [7:0] rdata,
                     input int delay, input int exp_stb, input logic [31:0] exp_word);
    @(posedge clk);
    #1 gp_out = req;
    observe(name, req, rdata, delay, exp_stb, exp_word);
  endtask

  typedef struct {
    logic [31:0] req;
    logic [7:0]  rdata;
    int          delay;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [6];

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          s;
    logic        tog;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  rd;
    logic [5:0]  rsvd;
    int          dly;
    logic [31:0] req;
    logic [31:0] expw;
    int          lat;

    n_checks  = 0;
    n_fail    = 0;
    stb_total = 0;
    both_hi   = 0;
    model_cnt = 0;
    last_exp  = 32'h0;
    reset_n   = 1'b0;
    gp_out    = 32'h0;
    bus_ready = 1'b0;
    bus_rdata = 8'h00;

    // Table: counts continue from 2 after the two test-plan transactions.
    tbl[0] = '{32'hBF000011, 8'h6B, 0, 32'h8000036B};
    tbl[1] = '{32'h40FFFFFF, 8'h77, 1, 32'h000004FF};
    tbl[2] = '{32'hC0800100, 8'hEE, 2, 32'h80000500};
    tbl[3] = '{32'h1500FF33, 8'h81, 3, 32'h00000681};
    tbl[4] = '{32'h80A5A55A, 8'h7E, 0, 32'h8000077E};
    tbl[5] = '{32'h6A13579C, 8'h00, 7, 32'h0000089C};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset gp_in", gp_in, 32'h0);
    chk("reset bus_rd", 32'(bus_rd), 32'd0);
    chk("reset bus_wr", 32'(bus_wr), 32'd0);
    chk("reset bus_addr", 32'(bus_addr), 32'd0);
    chk("reset bus_wdata", 32'(bus_wdata), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_reset idle strobes", 32'(stb_total), 32'd0);

    // Test-plan read and write
    run("tp_read", 32'h8012345A, 8'hC3, 0, 1, 32'h800001C3);
    model_cnt = 1;
    run("tp_write", 32'h407F00A5, 8'h00, 5, 6, 32'h000002A5);
    model_cnt = 2;

    // Unchanged request word: nothing happens for 100 cycles.
    s = stb_total;
    repeat (100) @(negedge clk);
    chk("hold strobes", 32'(stb_total - s), 32'd0);
    chk("hold gp_in", gp_in, 32'h000002A5);

    // New data but the same toggle is not a request.
    @(posedge clk);
    #1 gp_out = 32'h40DEADBE;
    s = stb_total;
    repeat (30) @(negedge clk);
    chk("same_toggle strobes", 32'(stb_total - s), 32'd0);
    chk("same_toggle gp_in", gp_in, 32'h000002A5);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      run($sformatf("tbl%0d", i), tbl[i].req, tbl[i].rdata, tbl[i].delay,
          tbl[i].delay + 1, tbl[i].exp);
    end
    model_cnt = 8;

    // Stalled bus: abort after TO cycles, or wait as long as it takes.
`ifdef GP_RESP_TIMEOUT_EN
    run("timeout", 32'h80424200, 8'h3C, 1000, TO, 32'hC00009FF);
`else
    run("long_wait", 32'h80424200, 8'h3C, 40, 41, 32'h8000093C);
`endif
    model_cnt = 9;

    // Randomized alternating-toggle requests against the transaction model.
    tog = 1'b0;
    for (int i = 0; i < 256; i++) begin
      wr   = ($urandom_range(0, 3) == 0);
      addr = 16'($urandom);
      wd   = 8'($urandom);
      rd   = 8'($urandom);
      rsvd = 6'($urandom);
      dly  = $urandom_range(0, 3);
      req  = mk_req(tog, wr, rsvd, addr, wd);
      model_cnt = (model_cnt + 1) % 256;
      expw = {tog, 1'b0, 14'd0, 8'(model_cnt), wr ? wd : rd};
      run($sformatf("rnd%0d", i), req, rd, dly, dly + 1, expw);
      if (model_cnt == 0) chk("wrap count", 32'(gp_in[15:8]), 32'd0);
      tog = ~tog;
    end

    // Bring the served toggle back to 0, then reset in the middle of a read.
    model_cnt = (model_cnt + 1) % 256;
    run("pre_reset", 32'h00000042, 8'h10, 0, 1, {16'h0000, 8'(model_cnt), 8'h10});

    @(posedge clk);
    #1 gp_out = 32'h80246800;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!bus_rd && lat < 20);
    chk("reset_access latency", 32'(lat), 32'(SYNC + 2));
    repeat (3) @(negedge clk);
    chk("reset_access busy", 32'(bus_rd), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset bus_rd", 32'(bus_rd), 32'd0);
    chk("async_reset bus_wr", 32'(bus_wr), 32'd0);
    chk("async_reset gp_in", gp_in, 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    last_exp  = 32'h0;
    model_cnt = 1;
    observe("reset_reserve", 32'h80246800, 8'h99, 1, 2, 32'h80000199);
    s = stb_total;
    repeat (30) @(negedge clk);
    chk("reserve_once strobes", 32'(stb_total - s), 32'd0);
    chk("reserve_once gp_in", gp_in, 32'h80000199);

    chk("never both strobes", 32'(both_hi), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hps_gp_responder.md
Name: hps_gp_responder

Overview:
- FPGA-fabric responder for the HPS general-purpose register mailbox.
- The HPS issues 8-bit read/write requests by writing its 32-bit GP output word (fabric input `gp_out`) with a toggle handshake bit.
- This block synchronises the request, performs one access on the fabric-side CPC peripheral bus, and returns completion through the 32-bit GP input word (fabric output `gp_in`).
- It sits between the HPS instance's GP ports and the CPC I/O and memory bus arbiter.

Parameters:
- SYNC_STAGES, 2: flop stages on every `gp_out` bit; legal values 2–4.
- ADDR_W, 16: bus address width, taken from `gp_out[8+ADDR_W-1:8]`; ADDR_W is at most 16.
- TIMEOUT_CYCLES, 1024: ACCESS cycles allowed before abort. Used only when GP_RESP_TIMEOUT_EN is defined.

Ports:
- clk, input, 1: fabric clock; all logic is on the rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- gp_out, input, 32: HPS request word, asynchronous to clk.
  - [31] request toggle.
  - [30] write flag (1 = write, 0 = read).
  - [29:24] reserved.
  - [23:8] address.
  - [7:0] write data.
- gp_in, output, 32: response word to the HPS.
  - [31] acknowledge toggle.
  - [30] error.
  - [29:16] zero.
  - [15:8] completed-transaction count.
  - [7:0] read data, or write-data echo.
- bus_addr, output, ADDR_W: access address.
- bus_wdata, output, 8: write data.
- bus_rd, output, 1: read strobe, held until ready.
- bus_wr, output, 1: write strobe, held until ready.
- bus_rdata, input, 8: read data, valid when bus_ready=1.
- bus_ready, input, 1: access completes on any cycle where ready=1 and a strobe is asserted.

Behaviour:
- Reset values: `gp_in`=0, `bus_rd`=0, `bus_wr`=0, `bus_addr`=0, `bus_wdata`=0, transaction count=0, last-toggle register=0, state=IDLE.
- Synchroniser: the full 32-bit `gp_out` passes through SYNC_STAGES flops, giving `sync_word`. The HPS changes the word only when `gp_in[31]` equals its own toggle, so data is stable while a request is pending.
- State machine:
  - IDLE: when `sync_word[31]` != last-toggle, go to SETTLE.
  - SETTLE: one cycle, guards against multi-bit skew.
    - Latch addr, wdata, wr flag and toggle from `sync_word`.
    - Drive `bus_addr` and `bus_wdata`.
    - Go to ACCESS.
  - ACCESS: assert `bus_wr` if the wr flag is set, otherwise `bus_rd`; exactly one strobe is high. On the cycle `bus_ready`=1:
    - capture `bus_rdata` (reads) or wdata (writes) into the result byte;
    - deassert the strobe on the next edge;
    - set err=0;
    - go to RESPOND.
  - RESPOND: one cycle.
    - `gp_in[7:0]` = result, `gp_in[30]` = err, `gp_in[31]` = latched toggle.
    - `gp_in[15:8]` increments by 1 with wrap (0xFF → 0x00). It increments on errors too.
    - last-toggle = latched toggle.
    - Go to IDLE.
- Latency:
  - `gp_out` toggle edge to strobe high: SYNC_STAGES+2 clk cycles.
  - `bus_ready` high to `gp_in` update: 2 cycles (the update is visible after the RESPOND edge).
- Strobes are never asserted outside ACCESS. `bus_addr` and `bus_wdata` hold their last values in IDLE.
- A toggle change seen during SETTLE, ACCESS or RESPOND is ignored until IDLE; it is a protocol violation by the HPS.
- A new toggle that equals last-toggle (no change) is never serviced.
- `bus_ready`=1 in IDLE or SETTLE is ignored.
- Reset mid-operation aborts immediately:
  - strobes drop asynchronously;
  - `gp_in`=0, so any pending HPS toggle=1 request is re-served after reset.
- Reserved bits `gp_out[29:24]` are ignored. For ADDR_W<16, upper address bits are ignored.

Optional Feature:
- Macro: GP_RESP_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES) clears on entry to ACCESS and increments each ACCESS cycle without ready.
  - When it reaches TIMEOUT_CYCLES-1 with `bus_ready`=0: drop the strobe, result=0xFF, err=1, go to RESPOND.
  - `bus_ready`=1 on that same cycle wins: normal completion, err=0.
- Undefined: no counter; ACCESS waits indefinitely; `gp_in[30]` is constant 0.

Test Plan:
- After reset: `gp_in`=0x00000000 and strobes low. Then `gp_out`=0x80_1234_5A (toggle 1, read, addr 0x1234), `bus_ready`=1 with `bus_rdata`=0xC3 → one `bus_rd` pulse at addr 0x1234, 4 cycles after the toggle. `gp_in` becomes 0x800001C3.
- `gp_out`=0x40_7F00_A5 (toggle 0, write), `bus_ready` low for 5 cycles then high → `bus_wr` held exactly 6 cycles with `bus_wdata`=0xA5. `gp_in`=0x000002A5.
- Hold `gp_out` unchanged after completion for 100 cycles → no further strobes and the count stays 0x02.
- 256 alternating-toggle reads → count wraps to 0x00 after the 256th response, and the ack bit tracks each toggle.
- With GP_RESP_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, read with `bus_ready` stuck at 0 → strobe drops after 16 ACCESS cycles. `gp_in[30]`=1, `gp_in[7:0]`=0xFF, ack toggle matches.
- Assert reset_n low while in ACCESS → strobes fall with no clock edge and `gp_in`=0. After release with the toggle still 1, the request is re-executed once.
